// File: rtl/mem_access_if.sv
// Bus bundle between the datapath, mem_access_ctrl and the byte-wide data memory.
// Datapath side: req, wr, addr, wdata in; busy, done, rdata back.
// Memory side : mem_addr, mem_data_in, mem_wen out; mem_data_out
//               (32-bit little-endian word starting at mem_addr) back.
// slave modport = the controller, master modport = everything around it.
interface mem_access_if;
   logic        req;
   logic        wr;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic [7:0]  mem_data_in;
   logic [7:0]  mem_addr;
   logic        mem_wen;
   logic [31:0] mem_data_out;

   modport slave (
      input  req, wr, addr, wdata, mem_data_out,
      output busy, done, rdata, mem_data_in, mem_addr, mem_wen
   );

   modport master (
      output req, wr, addr, wdata, mem_data_out,
      input  busy, done, rdata, mem_data_in, mem_addr, mem_wen
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Word load/store sequencer in front of a byte-wide data memory.
// A store is written as four byte writes (little-endian, base+0..base+3).
// A load is a single cycle, because the memory returns the whole word
// combinationally.
// Ports: clk, rst (synchronous, active high), bus (mem_access_if.slave).
//
// state | meaning
// IDLE  | waiting for req; the base address and store word are latched on req
// WRITE | one byte written per cycle, cnt selects the byte, 4 cycles total
// READ  | memory word presented at base; rdata captured on the next edge
// DONE  | one-cycle done pulse, then back to IDLE
module mem_access_ctrl (
   input  logic         clk,
   input  logic         rst,
   mem_access_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q;
   logic [7:0]  base_q;
   logic [31:0] word_q;
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         base_q  <= 8'd0;
         word_q  <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (bus.req) begin
                  base_q <= bus.addr;
                  word_q <= bus.wdata;
                  cnt_q  <= 2'd0;
               end
            end
            WRITE:   cnt_q   <= cnt_q + 2'd1;
            READ:    rdata_q <= bus.mem_data_out;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d         = state_q;
      bus.busy        = 1'b0;
      bus.done        = 1'b0;
      bus.mem_wen     = 1'b0;
      bus.mem_addr    = base_q;
      bus.mem_data_in = 8'd0;
      case (state_q)
         IDLE: begin
            if (bus.req) state_d = bus.wr ? WRITE : READ;
         end
         WRITE: begin
            bus.busy        = 1'b1;
            // A reset arriving mid-store must not let the byte currently on the
            // bus land at the reset edge, so the write strobe is held off by rst.
            bus.mem_wen     = ~rst;
            bus.mem_addr    = base_q + {6'd0, cnt_q};
            bus.mem_data_in = word_q[{cnt_q, 3'b000} +: 8];
            if (cnt_q == 2'd3) state_d = DONE;
         end
         READ: begin
            bus.busy = 1'b1;
            state_d  = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.rdata = rdata_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 req  input  1  access request from datapath; sampled only in IDLE.
REQ-005 wr  input  1  access type: 1 = store word, 0 = load word; sampled with req.
REQ-006 addr  input  8  byte base address; sampled with req.
REQ-007 wdata  input  32  store word; sampled with req.
REQ-008 busy  output  1  high in WRITE and READ states.
REQ-009 done  output  1  one-cycle completion pulse; high only in DONE state.
REQ-010 rdata  output  32  registered load result.
REQ-011 mem_data_in  output  8  byte to data_memory data_in.
REQ-012 mem_addr  output  8  byte address to data_memory address_in.
REQ-013 mem_wen  output  1  write enable to data_memory wen.
REQ-014 mem_data_out  input  32  data_memory data_out; combinational read, little-endian: [7:0]=byte@mem_addr, [15:8]=@+1, [23:16]=@+2, [31:24]=@+3 (mod 256).

Function
REQ-015 States: IDLE, WRITE, READ, DONE; 2-bit byte counter cnt; base address and store word latched in internal registers.
REQ-016 IDLE: req=1 at an edge latches addr/wdata, clears cnt; wr=1 -> WRITE, wr=0 -> READ; req=0 -> stay IDLE.
REQ-017 WRITE: mem_wen=1, mem_addr=base+cnt (mod 256), mem_data_in=wdata byte cnt (cnt=0 -> [7:0], 3 -> [31:24]); each edge increments cnt; edge with cnt=3 -> DONE.
REQ-018 Store latency: req sampled at edge N; bytes written at edges N+1..N+4; done high in the cycle after edge N+4.
REQ-019 READ: mem_wen=0, mem_addr=base; next edge loads rdata <= mem_data_out and -> DONE; load result valid when done rises (2 edges after req).
REQ-020 DONE: done=1, busy=0, mem_wen=0; next edge -> IDLE unconditionally.
REQ-021 req in WRITE, READ or DONE is ignored and never queued; addr/wdata/wr changes there have no effect.
REQ-022 Outside WRITE: mem_wen=0, mem_data_in=0; mem_addr=base register.
REQ-023 Address wrap: base+cnt truncated to 8 bits (base 0xFE -> 0xFE, 0xFF, 0x00, 0x01).
REQ-024 rdata changes only at the READ->DONE edge or on reset; stores leave it unchanged.
REQ-025 busy, done, mem_* decoded combinationally from state/cnt/latched registers; no glitch-relevant timing beyond one clock.

Reset
REQ-026 rst=1 at an edge forces IDLE, cnt=0, base=0, latched word=0, rdata=0; rst has priority over req.
REQ-027 After reset edge: busy=0, done=0, mem_wen=0, mem_addr=0, mem_data_in=0.
REQ-028 Reset mid-store aborts it: bytes written at earlier edges remain in memory, no further bytes written, done not asserted.

Verification
REQ-029 Reset: rst=1 one edge with req=1 -> all outputs 0, state IDLE, no memory write.
REQ-030 Store: req=1, wr=1, addr=0x00, wdata=0x08040200 -> mem writes 0x00@0, 0x02@1, 0x04@2, 0x08@3 on 4 consecutive edges; busy high 4 cycles; done pulse 1 cycle.
REQ-031 Load: req=1, wr=0, addr=0x00 after REQ-030 -> rdata=0x08040200 when done=1; mem_wen stays 0.
REQ-032 Wrap: store 0xDDCCBBAA at addr 0xFE -> 0xAA@0xFE, 0xBB@0xFF, 0xCC@0x00, 0xDD@0x01; load at 0xFE returns 0xDDCCBBAA.
REQ-033 Ignore while busy: second req (wr=1, addr=0x10) during store -> no write to 0x10..0x13; exactly one done pulse.
REQ-034 Reset mid-store: rst at edge after byte 1 written for store 0x44332211 @0x20 -> memory 0x11@0x20, 0x22@0x21 only; 0x22/0x23 unchanged; done never asserted.
